// File: rtl/count_match_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : count_match_ctrl
// Summary  : Prescaled up-counter with a latched compare value. It raises a
//            one-cycle match pulse and a sticky match flag, and runs either
//            one-shot or auto-reload.
// Revision : 1.0 - initial release
// ============================================================================
module count_match_ctrl #(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 1
) (
    input  logic             Clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    input  logic             reload,
    input  logic [WIDTH-1:0] match_val,
    output logic [WIDTH-1:0] count,
    output logic             match_pulse,
    output logic             match_flag,
    output logic             busy,
    output logic             done
);

    // The prescaler keeps at least one bit so that PRESCALE=1 stays legal.
    localparam int             c_PW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_PW-1:0] c_PS_MAX = c_PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_match;
    logic [c_PW-1:0]  r_presc;
    logic             r_pulse;
    logic             r_flag;
    logic             r_busy;
    logic             r_done;

    logic w_tick;
    assign w_tick = (r_presc == c_PS_MAX);

    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_match <= '0;
            r_presc <= '0;
            r_pulse <= 1'b0;
            r_flag  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_pulse <= 1'b0;
            // A match later in this block overrides the clear.
            if (clear) begin
                r_flag <= 1'b0;
            end
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state <= S_RUN;
                        r_count <= '0;
                        r_presc <= '0;
                        r_match <= match_val;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        r_state <= S_IDLE;
                        r_presc <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_presc <= w_tick ? '0 : r_presc + 1'b1;
                        if (w_tick) begin
                            if (r_count == r_match) begin
                                r_pulse <= 1'b1;
                                r_flag  <= 1'b1;
                                if (reload) begin
                                    r_count <= '0;
                                end else begin
                                    r_state <= S_DONE;
                                    r_busy  <= 1'b0;
                                    r_done  <= 1'b1;
                                end
                            end else begin
                                r_count <= r_count + 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign count       = r_count;
    assign match_pulse = r_pulse;
    assign match_flag  = r_flag;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_count_match_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_count_match_ctrl
// Summary  : Scoreboard bench: two instances (PRESCALE=1 and PRESCALE=2) with
//            per-instance queues of expected match pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_count_match_ctrl;

    logic       Clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       start2 = 1'b0;
    logic       stop = 1'b0;
    logic       clear = 1'b0;
    logic       reload = 1'b0;
    logic [3:0] match_val = 4'd0;

    logic [3:0] count_a, count_b;
    logic       pulse_a, pulse_b, flag_a, flag_b, busy_a, busy_b, done_a, done_b;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int n      = 0;

    typedef struct {
        int         cyc;
        logic [3:0] cnt;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    count_match_ctrl #(.WIDTH(4), .PRESCALE(1)) u_dut_a (
        .Clk(Clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
        .reload(reload), .match_val(match_val), .count(count_a),
        .match_pulse(pulse_a), .match_flag(flag_a), .busy(busy_a), .done(done_a)
    );

    count_match_ctrl #(.WIDTH(4), .PRESCALE(2)) u_dut_b (
        .Clk(Clk), .rst(rst), .start(start2), .stop(stop), .clear(clear),
        .reload(reload), .match_val(match_val), .count(count_b),
        .match_pulse(pulse_b), .match_flag(flag_b), .busy(busy_b), .done(done_b)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitors: every pulse must match the head of its queue.
    always @(negedge Clk) begin
        if (pulse_a === 1'b1) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_pulse", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = qa.pop_front();
                chk("a_pulse_edge", cyc, e.cyc);
                chk("a_pulse_count", {28'd0, count_a}, {28'd0, e.cnt});
                chk("a_pulse_flag", {31'd0, flag_a}, 32'd1);
            end
        end
    end

    always @(negedge Clk) begin
        if (pulse_b === 1'b1) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_pulse", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = qb.pop_front();
                chk("b_pulse_edge", cyc, e.cyc);
                chk("b_pulse_count", {28'd0, count_b}, {28'd0, e.cnt});
                chk("b_pulse_flag", {31'd0, flag_b}, 32'd1);
            end
        end
    end

    task automatic chk_a(input string name, input logic [3:0] c, input logic b,
                         input logic d, input logic f);
        chk({name, "_count"}, {28'd0, count_a}, {28'd0, c});
        chk({name, "_busy"}, {31'd0, busy_a}, {31'd0, b});
        chk({name, "_done"}, {31'd0, done_a}, {31'd0, d});
        chk({name, "_flag"}, {31'd0, flag_a}, {31'd0, f});
    endtask

    // Launch a run on instance A from a negedge; n = the start edge.
    task automatic go_a(input logic [3:0] mv, input logic rl);
        match_val = mv;
        reload    = rl;
        start     = 1'b1;
        n         = cyc + 1;
        @(negedge Clk);
        start     = 1'b0;
    endtask

    initial begin
        // Reset takes effect with no clock edge.
        #1 rst = 1'b1;
        #1;
        chk_a("rst", 4'd0, 1'b0, 1'b0, 1'b0);
        chk("rst_pulse_a", {31'd0, pulse_a}, 32'd0);
        chk("rst_busy_b", {31'd0, busy_b}, 32'd0);
        chk("rst_count_b", {28'd0, count_b}, 32'd0);
        repeat (2) @(negedge Clk);
        rst = 1'b0;
        @(negedge Clk);

        // 1: one-shot, match 6, pulse 7 edges after start
        qa.push_back('{cyc + 1 + 7, 4'd6});
        go_a(4'd6, 1'b0);
        for (int k = 0; k <= 6; k++) begin
            chk("t1_seq", {28'd0, count_a}, k);
            chk("t1_busy", {31'd0, busy_a}, 32'd1);
            @(negedge Clk);
        end
        chk_a("t1_end", 4'd6, 1'b0, 1'b1, 1'b1);

        // 4: clear alone, then clear coinciding with a match edge
        clear = 1'b1;
        @(negedge Clk);
        clear = 1'b0;
        chk_a("t4_clr", 4'd6, 1'b0, 1'b1, 1'b0);
        qa.push_back('{cyc + 1 + 3, 4'd2});
        go_a(4'd2, 1'b0);
        repeat (2) @(negedge Clk);
        clear = 1'b1;
        @(negedge Clk);
        clear = 1'b0;
        chk_a("t4_setwins", 4'd2, 1'b0, 1'b1, 1'b1);
        clear = 1'b1;
        @(negedge Clk);
        clear = 1'b0;
        chk_a("t4_late_clr", 4'd2, 1'b0, 1'b1, 1'b0);

        // 3: stop at count 2 on a tick edge; no pulse may follow
        go_a(4'd5, 1'b0);
        repeat (2) @(negedge Clk);
        chk("t3_pre_stop", {28'd0, count_a}, 32'd2);
        stop = 1'b1;
        @(negedge Clk);
        stop = 1'b0;
        chk_a("t3_stop", 4'd2, 1'b0, 1'b0, 1'b0);
        repeat (6) @(negedge Clk);
        chk_a("t3_idle", 4'd2, 1'b0, 1'b0, 1'b0);

        // start+stop in IDLE: start wins; start in RUN keeps match_reg
        qa.push_back('{cyc + 1 + 2, 4'd1});
        match_val = 4'd1;
        stop  = 1'b1;
        go_a(4'd1, 1'b0);
        stop  = 1'b0;
        chk_a("t3_restart", 4'd0, 1'b1, 1'b0, 1'b0);
        match_val = 4'd9;
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        chk_a("t3_start_in_run", 4'd1, 1'b1, 1'b0, 1'b0);
        @(negedge Clk);
        chk_a("t3_done", 4'd1, 1'b0, 1'b1, 1'b1);

        // 5: match 0 hits on the first tick; match 15 reaches 15 without wrap
        qa.push_back('{cyc + 1 + 1, 4'd0});
        go_a(4'd0, 1'b0);
        @(negedge Clk);
        chk_a("t5_zero", 4'd0, 1'b0, 1'b1, 1'b1);
        qa.push_back('{cyc + 1 + 16, 4'd15});
        go_a(4'd15, 1'b0);
        repeat (15) @(negedge Clk);
        chk_a("t5_at15", 4'd15, 1'b1, 1'b0, 1'b1);
        @(negedge Clk);
        chk_a("t5_max", 4'd15, 1'b0, 1'b1, 1'b1);
        repeat (2) @(negedge Clk);
        chk("t5_hold", {28'd0, count_a}, 32'd15);

        // 2: instance B, PRESCALE=2, match 3, auto-reload
        clear = 1'b1;
        @(negedge Clk);
        clear = 1'b0;
        match_val = 4'd3;
        reload    = 1'b1;
        start2    = 1'b1;
        n         = cyc + 1;
        qb.push_back('{n + 8, 4'd0});
        qb.push_back('{n + 16, 4'd0});
        qb.push_back('{n + 24, 4'd0});
        @(negedge Clk);
        start2 = 1'b0;
        for (int k = 0; k < 24; k++) begin
            chk("t2_seq", {28'd0, count_b}, (k % 8) / 2);
            chk("t2_busy", {31'd0, busy_b}, 32'd1);
            chk("t2_done", {31'd0, done_b}, 32'd0);
            @(negedge Clk);
        end
        stop = 1'b1;
        @(negedge Clk);
        stop = 1'b0;
        chk("t2_stopped", {31'd0, busy_b}, 32'd0);
        chk("t2_flag", {31'd0, flag_b}, 32'd1);

        // 6: asynchronous reset in the middle of a run
        go_a(4'd10, 1'b1);
        repeat (3) @(negedge Clk);
        chk("t6_running", {28'd0, count_a}, 32'd3);
        #2 rst = 1'b1;
        #1;
        chk_a("t6_async", 4'd0, 1'b0, 1'b0, 1'b0);
        chk("t6_flag_b", {31'd0, flag_b}, 32'd0);
        @(negedge Clk);
        rst = 1'b0;
        repeat (4) @(negedge Clk);
        chk_a("t6_idle", 4'd0, 1'b0, 1'b0, 1'b0);

        chk("qa_drained", qa.size(), 32'd0);
        chk("qb_drained", qb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
